stopwatch_up_count: RTL
=======================

Name: stopwatch_up_count

Overview:
- Four-digit BCD elapsed-time counter (MM:SS, 00:00 to 59:59) for the stopwatch.
- Counts up on a 1 Hz enable pulse under start/stop/clear/lap control.
- It is the up-counting counterpart of the existing mod-10 down-count digit logic.
- Sits between the tick prescaler and the 7-segment display mux.

Parameters:
- WRAP, 1: 1 = roll 59:59 to 00:00 and keep running; 0 = saturate at 59:59 and enter PAUSE.
- MIN_TENS_MAX, 5: maximum value of the minute-tens digit (BCD, 1..9).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk-wide 1 Hz count-enable pulse.
- start  in  1  level-sampled each clk; request to run.
- stop  in  1  level-sampled each clk; request to pause.
- clear  in  1  zero the count and return to IDLE.
- lap  in  1  toggle freeze of the displayed value.
- sec_ones  out  4  displayed seconds units, 0..9.
- sec_tens  out  4  displayed seconds tens, 0..5.
- min_ones  out  4  displayed minutes units, 0..9.
- min_tens  out  4  displayed minutes tens, 0..MIN_TENS_MAX.
- running  out  1  high while the state is RUN.
- lap_active  out  1  high while the display is frozen.
- overflow  out  1  one-clk pulse when a tick occurs at the maximum count.

Behaviour:
- Reset (async, active-high):
  - State = IDLE; live count = 00:00; lap register = 00:00.
  - lap_active = 0, running = 0, overflow = 0.
  - Every digit output reads 0.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE.
  - PAUSE: start -> RUN.
  - clear from any state -> IDLE.
  - If start and stop are both high in one cycle, stop wins.
  - clear has priority over start, stop and tick.
- Counting:
  - Only in RUN, and only on cycles with tick = 1.
  - New count is visible on the outputs the cycle after the tick (1-cycle latency).
  - sec_ones 9 -> 0 with carry.
  - sec_tens 5 -> 0 with carry.
  - min_ones 9 -> 0 with carry.
  - min_tens MIN_TENS_MAX -> 0 with carry-out.
  - Carries ripple combinationally in the same cycle; all four digits update on the same edge.
- Maximum count (tick at MIN_TENS_MAX9:59):
  - overflow pulses high for that one cycle.
  - WRAP = 1: count becomes 00:00 and the state stays RUN.
  - WRAP = 0: count holds at the maximum and the state goes to PAUSE.
- A tick that coincides with a start in PAUSE is not counted; counting begins on the next tick.
- A tick in IDLE or PAUSE is ignored.
- Lap:
  - A lap pulse while lap_active = 0 copies the live count into the lap register and sets lap_active.
  - A lap pulse while lap_active = 1 clears lap_active.
  - The live count keeps advancing underneath a frozen display.
- Display select: outputs show the lap register when lap_active = 1, otherwise the live count.
- clear also clears lap_active and the lap register.
- Digit values never leave BCD range. No illegal digit values are reachable; any out-of-range digit is forced to 0 on its next update.

Decomposition:
- Package stopwatch_pkg holds:
  - the sw_state_t enum {IDLE, RUN, PAUSE};
  - bcd_t (logic [3:0]);
  - constants DIGIT_MAX = 9 and TENS_MAX = 5.
- One sub-module, bcd_up_digit: a single mod-(MAX+1) up-counting digit.
  - Parameter: MAX.
  - Ports: clk, rst, clr, inc_en, q[3:0], carry_out.
  - carry_out = inc_en & (q == MAX).
- The top level instantiates four bcd_up_digit instances, chained carry_out -> inc_en, plus the FSM and the lap register.

Test Plan:
- Reset check: rst pulse mid-count at 12:34 -> next sampled outputs 00:00 with running = 0; issue start then 3 ticks -> 00:03.
- Seconds-tens carry: run from 00:00 with 59 ticks -> 00:59; 1 more tick -> 01:00; no overflow pulse.
- Wrap (WRAP = 1): preload via 3599 ticks to 59:59, then 1 tick -> 00:00, overflow high exactly 1 cycle, running stays 1.
- Saturate (WRAP = 0): at 59:59, 1 tick -> still 59:59, overflow for 1 cycle, running = 0; a further start plus tick repeats the same response.
- Control priority: at 00:07, assert start + stop + tick together -> PAUSE, count stays 00:07; assert clear + tick together -> 00:00 and IDLE.
- Lap: lap at 00:10, then 5 ticks -> display 00:10 with lap_active = 1; second lap -> display 00:15 and lap_active = 0.

Source files
------------

// File: rtl/stopwatch_up_count_pkg.sv
// Shared types and constants for the stopwatch elapsed-time counter.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t DIGIT_MAX = 4'd9;
   localparam bcd_t TENS_MAX  = 4'd5;

endpackage

// File: rtl/stopwatch_up_count_bcd_up_digit.sv
// One mod-(MAX+1) up-counting BCD digit. carry_out is combinational so a
// chain of digits ripples its carries within a single cycle.
module bcd_up_digit
   import stopwatch_pkg::*;
#(
   parameter bcd_t MAX = DIGIT_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc_en,
   output bcd_t q,
   output logic carry_out
);

   assign carry_out = inc_en & (q == MAX);

   // Digit register: clear wins, otherwise advance and roll over at MAX;
   // any out-of-range value is pulled back to 0 on its next increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc_en) begin
         q <= (q >= MAX) ? '0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_up_count.sv
// Four-digit BCD MM:SS up-counter with start/stop/clear control and a lap
// freeze. Sits between the 1 Hz tick prescaler and the display mux.
module stopwatch_up_count
   import stopwatch_pkg::*;
#(
   parameter bit WRAP         = 1'b1,
   parameter int MIN_TENS_MAX = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   localparam bcd_t MT_MAX = bcd_t'(MIN_TENS_MAX);

   sw_state_t state;

   bcd_t live_so, live_st, live_mo, live_mt;
   bcd_t lap_so, lap_st, lap_mo, lap_mt;
   logic c_so, c_st, c_mo, c_mt;

   logic at_max;
   logic cnt_req;
   logic cnt_en;
   logic ovf_nxt;

   // A tick counts only while running; stop and clear both suppress it.
   assign cnt_req = (state == RUN) & tick & ~stop & ~clear;

   assign at_max = (live_mt == MT_MAX)   & (live_mo == DIGIT_MAX) &
                   (live_st == TENS_MAX) & (live_so == DIGIT_MAX);

   // In saturating mode the digit chain is held at the maximum.
   assign cnt_en = cnt_req & (WRAP | ~at_max);

   // With wrapping the top carry-out is exactly the overflow condition;
   // when saturating the chain is gated so the condition is decoded directly.
   assign ovf_nxt = WRAP ? c_mt : (cnt_req & at_max);

   bcd_up_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
      .clk(clk), .rst(rst), .clr(clear), .inc_en(cnt_en),
      .q(live_so), .carry_out(c_so)
   );

   bcd_up_digit #(.MAX(TENS_MAX)) u_sec_tens (
      .clk(clk), .rst(rst), .clr(clear), .inc_en(c_so),
      .q(live_st), .carry_out(c_st)
   );

   bcd_up_digit #(.MAX(DIGIT_MAX)) u_min_ones (
      .clk(clk), .rst(rst), .clr(clear), .inc_en(c_st),
      .q(live_mo), .carry_out(c_mo)
   );

   bcd_up_digit #(.MAX(MT_MAX)) u_min_tens (
      .clk(clk), .rst(rst), .clr(clear), .inc_en(c_mo),
      .q(live_mt), .carry_out(c_mt)
   );

   // Run-control FSM and registered overflow pulse; clear overrides all,
   // and stop beats a simultaneous start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         overflow <= 1'b0;
      end else begin
         overflow <= ovf_nxt;
         if (clear) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE:    if (start && !stop) state <= RUN;
               RUN: begin
                  if (stop)                          state <= PAUSE;
                  else if (tick && at_max && !WRAP)  state <= PAUSE;
               end
               PAUSE:   if (start && !stop) state <= RUN;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Lap register: first lap pulse snapshots the live count, second releases it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_active <= 1'b0;
         lap_so     <= '0;
         lap_st     <= '0;
         lap_mo     <= '0;
         lap_mt     <= '0;
      end else if (clear) begin
         lap_active <= 1'b0;
         lap_so     <= '0;
         lap_st     <= '0;
         lap_mo     <= '0;
         lap_mt     <= '0;
      end else if (lap) begin
         if (!lap_active) begin
            lap_active <= 1'b1;
            lap_so     <= live_so;
            lap_st     <= live_st;
            lap_mo     <= live_mo;
            lap_mt     <= live_mt;
         end else begin
            lap_active <= 1'b0;
         end
      end
   end

   assign running  = (state == RUN);
   assign sec_ones = lap_active ? lap_so : live_so;
   assign sec_tens = lap_active ? lap_st : live_st;
   assign min_ones = lap_active ? lap_mo : live_mo;
   assign min_tens = lap_active ? lap_mt : live_mt;

endmodule
